delta_batcher: RTL and testbench

Upstream companion to the up/down delta counter. It accepts a stream of signed count updates over a valid/ready handshake and merges consecutive compatible updates into one accumulated delta. It issues that delta to the counter as a single-cycle `en`/`down`/`delta` strobe, which reduces counter update traffic. An issue is triggered by saturation, direction change, age timeout, or explicit flush. `hold_i` suppresses issues while the counter is being cleared or loaded.

---
 rtl/delta_batcher.sv | 155 +++++++++++++++
 tb/tb_delta_batcher.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/delta_batcher.sv
// Merges a stream of signed count updates into accumulated deltas and issues them
// to the up/down counter as single-cycle strobes. Optional macro: DELTA_BATCHER_NETTING_EN.
module delta_batcher #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             down_i,
    input  logic [WIDTH-1:0] delta_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             en_o,
    output logic             down_o,
    output logic [WIDTH-1:0] delta_o,
    output logic             pending_o
);

    localparam int               AGE_W    = $clog2(TIMEOUT) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               dir_q, dir_d;
    logic [AGE_W-1:0]   age_q, age_d;

    logic               issue;
    logic [WIDTH-1:0]   issue_delta;
    logic               issue_dir;
    logic [WIDTH-1:0]   merged;
    logic               merged_dir;
    logic               conflict;
    logic               empty;

    logic               accept;
    logic [WIDTH:0]     sum;
    logic               same_dir;
    logic [AGE_W-1:0]   age_inc;

    assign ready_o   = !(hold_i && state_q == ACCUM);
    assign pending_o = (state_q == ACCUM);

    // Zero-magnitude updates are handshaken but never touch the accumulator.
    assign accept   = valid_i && ready_o && (delta_i != '0);
    assign sum      = {1'b0, acc_q} + {1'b0, delta_i};
    assign same_dir = (down_i == dir_q);
    assign age_inc  = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        dir_d       = dir_q;
        age_d       = age_q;
        issue       = 1'b0;
        issue_delta = acc_q;
        issue_dir   = dir_q;
        merged      = acc_q;
        merged_dir  = dir_q;
        conflict    = 1'b0;
        empty       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d = delta_i;
                    dir_d = down_i;
                    age_d = '0;
                    if (!hold_i && (flush_i || delta_i == ALL_ONES)) begin
                        issue       = 1'b1;
                        issue_delta = delta_i;
                        issue_dir   = down_i;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end

            ACCUM: begin
                age_d = age_inc;
                if (accept) begin
                    if (same_dir && !sum[WIDTH]) begin
                        merged = sum[WIDTH-1:0];
`ifdef DELTA_BATCHER_NETTING_EN
                    end else if (!same_dir) begin
                        if (delta_i < acc_q) begin
                            merged = acc_q - delta_i;
                        end else if (delta_i == acc_q) begin
                            empty = 1'b1;
                        end else begin
                            merged     = delta_i - acc_q;
                            merged_dir = !dir_q;
                        end
`endif
                    end else begin
                        // Flush the old batch and start a new one from this update.
                        conflict = 1'b1;
                        issue    = 1'b1;
                        acc_d    = delta_i;
                        dir_d    = down_i;
                        age_d    = '0;
                    end
                end

                if (empty) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else if (!conflict) begin
                    acc_d = merged;
                    dir_d = merged_dir;
                    if (!hold_i && (flush_i || age_q == AGE_MAX || merged == ALL_ONES)) begin
                        issue       = 1'b1;
                        issue_delta = merged;
                        issue_dir   = merged_dir;
                        state_d     = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dir_q   <= 1'b0;
            age_q   <= '0;
            en_o    <= 1'b0;
            down_o  <= 1'b0;
            delta_o <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dir_q   <= dir_d;
            age_q   <= age_d;
            en_o    <= issue;
            if (issue) begin
                down_o  <= issue_dir;
                delta_o <= issue_delta;
            end
        end
    end

endmodule

// File: tb/tb_delta_batcher.sv
// Self-checking bench for delta_batcher: directed scenarios plus random traffic,
// compared every cycle against a signed-net behavioural model.
module tb_delta_batcher;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 4;
    localparam int MAXV    = (1 << WIDTH) - 1;
`ifdef DELTA_BATCHER_NETTING_EN
    localparam bit NETTING = 1'b1;
`else
    localparam bit NETTING = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic             down_i = 1'b0;
    logic [WIDTH-1:0] delta_i = '0;
    logic             flush_i = 1'b0;
    logic             hold_i = 1'b0;
    logic             en_o;
    logic             down_o;
    logic [WIDTH-1:0] delta_o;
    logic             pending_o;

    always #5 clk = ~clk;

    delta_batcher #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .down_i    (down_i),
        .delta_i   (delta_i),
        .flush_i   (flush_i),
        .hold_i    (hold_i),
        .en_o      (en_o),
        .down_o    (down_o),
        .delta_o   (delta_o),
        .pending_o (pending_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: signed net pending amount (positive = up) and cycles spent pending.
    int net       = 0;
    int age       = 0;
    bit exp_en    = 1'b0;
    bit exp_down  = 1'b0;
    int exp_delta = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    task automatic model_step(input bit v, input bit d, input int x, input bit f,
                              input bit h, input bit r);
        int  s;
        bit  take;
        bit  aged;
        bit  conflict;
        bit  issued;
        int  iss_mag;
        bit  iss_down;
        s        = d ? -x : x;
        take     = v && !(h && net != 0) && x != 0;
        aged     = (age == TIMEOUT - 1);
        conflict = 1'b0;
        issued   = 1'b0;
        iss_mag  = 0;
        iss_down = 1'b0;
        if (r) begin
            net = 0; age = 0;
            exp_en = 1'b0; exp_delta = 0; exp_down = 1'b0;
            return;
        end
        if (net == 0) begin
            if (take) begin
                net = s;
                age = 0;
                if (!h && (f || x == MAXV)) begin
                    issued = 1'b1; iss_mag = x; iss_down = d; net = 0;
                end
            end
        end else begin
            if (take) begin
                if (((s > 0) == (net > 0)) && (iabs(net) + x <= MAXV)) begin
                    net += s;
                end else if (((s > 0) != (net > 0)) && NETTING) begin
                    net += s;
                end else begin
                    conflict = 1'b1;
                    issued   = 1'b1;
                    iss_mag  = iabs(net);
                    iss_down = (net < 0);
                    net      = s;
                    age      = 0;
                end
            end
            if (!conflict && net != 0) begin
                if (!h && (f || aged || iabs(net) == MAXV)) begin
                    issued = 1'b1; iss_mag = iabs(net); iss_down = (net < 0); net = 0;
                end else if (age < TIMEOUT - 1) begin
                    age++;
                end
            end
        end
        exp_en = issued;
        if (issued) begin
            exp_delta = iss_mag;
            exp_down  = iss_down;
        end
    endtask

    task automatic cycle(input bit v, input bit d, input int x, input bit f,
                         input bit h, input bit r);
        @(negedge clk);
        check("en_o", en_o, exp_en);
        check("delta_o", delta_o, exp_delta);
        check("down_o", down_o, exp_down);
        check("pending_o", pending_o, (net != 0));
        valid_i = v;
        down_i  = d;
        delta_i = x[WIDTH-1:0];
        flush_i = f;
        hold_i  = h;
        rst_i   = r;
        #1;
        check("ready_o", ready_o, !(h && net != 0));
        model_step(v, d, x, f, h, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic upd(input bit d, input int x);
        cycle(1'b1, d, x, 1'b0, 1'b0, 1'b0);
    endtask

    int hold_left = 0;

    initial begin
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

        // Three compatible ups batched into one timeout issue.
        upd(1'b0, 3); upd(1'b0, 4); upd(1'b0, 5); idle(6);
        // Overflowing same-direction update.
        upd(1'b0, 10); upd(1'b0, 9); idle(6);
        // Opposite-direction update, then exact cancellation.
        upd(1'b0, 5); upd(1'b1, 2); idle(6);
        upd(1'b0, 7); upd(1'b1, 7); idle(6);
        // Timeout under hold, with updates offered while blocked.
        upd(1'b0, 6);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 3, 1'b0, 1'b1, 1'b0);
        idle(4);
        // Reset discards the pending batch.
        upd(1'b0, 6); idle(1);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        idle(4);
        // All-ones down issues at once; zero update does nothing.
        upd(1'b1, 15); upd(1'b0, 0); idle(2);
        // Flush with update in IDLE and flush of a pending batch.
        cycle(1'b1, 1'b1, 4, 1'b1, 1'b0, 1'b0); idle(1);
        upd(1'b0, 2); cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0); idle(2);

        for (int i = 0; i < 3000; i++) begin
            bit v, d, f, h, r;
            int x;
            if (hold_left == 0 && $urandom_range(0, 19) == 0) hold_left = $urandom_range(1, 8);
            h = (hold_left != 0);
            if (hold_left != 0) hold_left--;
            v = ($urandom_range(0, 2) != 0);
            d = $urandom_range(0, 1);
            x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 5);
            f = ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 199) == 0);
            cycle(v, d, x, f, h, r);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
